// File: rtl/imem_loader.sv
// Program loader: parses a word-count header from a byte stream, assembles
// little-endian 32-bit words and writes them to instruction memory from address 0.
module imem_loader #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int          IW    = $clog2(DEPTH_WORDS) + 1;
   localparam logic [16:0] MAX_N = 17'(DEPTH_WORDS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LEN_LO = 3'd1;
   localparam logic [2:0] S_LEN_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_WRITE  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [31:0]   word_q, word_d;

   logic [15:0]   n_hdr;
   logic          xfer;

   // Handshake and status outputs are pure decodes of the state register.
   assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
   assign imem_we    = (state_q == S_WRITE);
   assign busy       = byte_ready || imem_we;
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERR);
   assign cpu_hold   = (state_q != S_DONE);
   assign imem_addr  = 32'({idx_q, 2'b00});
   assign imem_wdata = word_q;

   assign xfer  = byte_valid && byte_ready;
   assign n_hdr = {byte_data, len_q[7:0]};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = byte_data;
               state_d    = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = byte_data;
               idx_d       = '0;
               cnt_d       = '0;
               if (n_hdr == 16'd0 || {1'b0, n_hdr} > MAX_N) state_d = S_ERR;
               else                                          state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer) begin
               word_d[{cnt_q, 3'b000} +: 8] = byte_data;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (16'(idx_q) == len_q - 16'd1) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = S_DATA;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads compared
// against a stream-level model of the expected memory writes.
module tb_imem_loader;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready, imem_we, cpu_hold, busy, done, error;
   logic [31:0] imem_addr, imem_wdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   int          sess_bytes = 0;
   logic        prev_we = 1'b0;

   imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .byte_valid(byte_valid),
      .byte_data (byte_data),
      .byte_ready(byte_ready),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bus monitor: records writes, checks single-cycle strobes and that each
   // write follows exactly the 4th byte of its word.
   always @(negedge clk) begin
      if (imem_we) begin
         check("we_single_cycle", {31'b0, prev_we}, 32'd0);
         check("we_after_4th_byte", sess_bytes, 2 + 4 * (obs_addr.size() + 1));
         obs_addr.push_back(imem_addr);
         obs_data.push_back(imem_wdata);
      end
      if (byte_valid && byte_ready) sess_bytes++;
      prev_we = imem_we;
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_hold"},   cpu_hold,   1);
      check({tag, "_byte_ready"}, byte_ready, 0);
      check({tag, "_imem_we"},    imem_we,    0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_done"},       done,       0);
      check({tag, "_error"},      error,      0);
      check({tag, "_imem_addr"},  imem_addr,  0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
   endtask

   task automatic clear_session();
      obs_addr.delete();
      obs_data.delete();
      sess_bytes = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] b[$], input int max_gap);
      int   gap;
      logic acc;
      foreach (b[i]) begin
         gap = $urandom_range(max_gap, 0);
         byte_valid = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
         byte_valid = 1'b1;
         byte_data  = b[i];
         acc = 1'b0;
         for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
         end
         check("byte_accepted", {31'b0, acc}, 32'd1);
      end
      byte_valid = 1'b0;
   endtask

   // Reference model: derives the expected outcome from the stream alone.
   task automatic finish_session(input string tag, input logic [7:0] s[$]);
      int          n, nexp, ncmp;
      bit          exp_err;
      logic [31:0] w;
      n       = int'({s[1], s[0]});
      exp_err = (n == 0) || (n > DEPTH);
      nexp    = exp_err ? 0 : n;
      for (int c = 0; c < 200 && !(done || error); c++) begin @(posedge clk); #1; end
      check({tag, "_error"},    error,    exp_err ? 1 : 0);
      check({tag, "_done"},     done,     exp_err ? 0 : 1);
      check({tag, "_cpu_hold"}, cpu_hold, exp_err ? 1 : 0);
      check({tag, "_busy"},     busy,     0);
      check({tag, "_nwrites"},  obs_addr.size(), nexp);
      ncmp = (obs_addr.size() < nexp) ? obs_addr.size() : nexp;
      for (int i = 0; i < ncmp; i++) begin
         w = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
         check({tag, "_addr"}, obs_addr[i], 32'(i * 4));
         check({tag, "_data"}, obs_data[i], w);
      end
   endtask

   task automatic make_stream(input int n, output logic [7:0] s[$]);
      s.delete();
      s.push_back(8'(n));
      s.push_back(8'(n >> 8));
      for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
   endtask

   initial begin
      logic [7:0] basic[$];
      logic [7:0] s[$];
      logic [7:0] part[$];

      basic = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'ha0, 8'h00};

      // Asynchronous reset asserted between clock edges.
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("idle");

      // Basic load with valid held high.
      clear_session(); pulse_start();
      send_bytes(basic, 0);
      finish_session("basic", basic);

      // Same stream with random valid gaps.
      clear_session(); pulse_start();
      send_bytes(basic, 5);
      finish_session("stall", basic);

      // Header rejection: N=0 and N=257, then recovery.
      s = '{8'h00, 8'h00};
      clear_session(); pulse_start();
      send_bytes(s, 0);
      finish_session("hdr_zero", s);
      s = '{8'h01, 8'h01};
      clear_session(); pulse_start();
      send_bytes(s, 0);
      finish_session("hdr_257", s);
      make_stream(1, s);
      clear_session(); pulse_start();
      check("err_cleared", error, 0);
      send_bytes(s, 2);
      finish_session("recover", s);

      // Reset after the first write plus two bytes of the second word.
      clear_session(); pulse_start();
      part = basic[0:7];
      send_bytes(part, 0);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("midload");
      check("midload_nwrites", obs_addr.size(), 1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clear_session(); pulse_start();
      send_bytes(basic, 1);
      finish_session("post_reset", basic);

      // start during DATA is ignored.
      clear_session(); pulse_start();
      part = basic[0:3];
      send_bytes(part, 0);
      pulse_start();
      check("start_in_data_busy", busy, 1);
      part = basic[4:9];
      send_bytes(part, 0);
      finish_session("start_in_data", basic);

      // start in DONE with a simultaneous byte: byte dropped, new load from 0.
      clear_session();
      start = 1'b1; byte_valid = 1'b1; byte_data = 8'h55;
      @(posedge clk); #1;
      start = 1'b0; byte_valid = 1'b0;
      check("restart_done",     done,     0);
      check("restart_cpu_hold", cpu_hold, 1);
      check("restart_busy",     busy,     1);
      make_stream(1, s);
      send_bytes(s, 0);
      finish_session("restart", s);

      // Randomized loads.
      for (int t = 0; t < 4; t++) begin
         make_stream($urandom_range(8, 1), s);
         clear_session(); pulse_start();
         send_bytes(s, 3);
         finish_session("random", s);
      end

      // Largest accepted load.
      make_stream(DEPTH, s);
      clear_session(); pulse_start();
      send_bytes(s, 0);
      finish_session("max_depth", s);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes instruction words into instruction memory before the processor runs. It accepts a byte stream over a valid/ready handshake, parses a 16-bit word-count header, assembles little-endian 32-bit instruction words, and issues one write per word at consecutive byte addresses from 0. It holds the processor in reset until the load completes. It is the write-side counterpart of the processor's instruction fetch path: the processor reads instruction memory by byte address, and this block fills it.

## Interface
- DEPTH_WORDS, 256: maximum number of instruction words accepted per load.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load session.
- byte_valid  in  1  a byte is offered on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  32  byte address of the write (word index × 4).
- imem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  processor reset/hold request; high while not loaded.
- busy  out  1  load session in progress.
- done  out  1  last load completed successfully.
- error  out  1  header rejected.

## Operation
- Stream format: len_lo, len_hi (N = {len_hi, len_lo} words), then 4N bytes. Each word is little-endian, so the first byte goes to wdata[7:0].
- A byte transfers on a rising edge where byte_valid && byte_ready. byte_ready is a function of registered state only and never of byte_valid.
- States:
  - IDLE: byte_ready=0. start → LEN_LO.
  - LEN_LO: byte_ready=1. Byte → len[7:0], then LEN_HI.
  - LEN_HI: byte_ready=1. Byte → len[15:8]. If N==0 or N>DEPTH_WORDS → ERR, otherwise → DATA with word index 0 and byte count 0.
  - DATA: byte_ready=1. Each byte fills the lane selected by the 2-bit byte count. The 4th byte → WRITE.
  - WRITE: byte_ready=0. imem_we=1, imem_addr=index×4, imem_wdata=assembled word. If index==N−1 → DONE, otherwise index+1 → DATA.
  - DONE: done=1, cpu_hold=0. start → LEN_LO.
  - ERR: error=1, cpu_hold=1. start → LEN_LO.
- busy=1 in LEN_LO, LEN_HI, DATA and WRITE.
- cpu_hold=1 in every state except DONE.
- Entering LEN_LO from DONE or ERR clears done and error in the same edge.
- start is ignored while busy.
- Bytes offered in IDLE, WRITE, DONE or ERR are not accepted.
- The word index is ceil(log2(DEPTH_WORDS))+1 bits wide. imem_addr is zero-extended to 32 bits.
- Words already written stay in memory after an error or reset. The loader never clears memory.

## Timing
- All outputs are registered or decoded from registered state.
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - cpu_hold=1.
  - byte_ready=0, imem_we=0, busy=0, done=0, error=0.
  - imem_addr=0, imem_wdata=0.
  - The length, index and byte count registers are cleared.
- Write latency: the 4th byte of a word is accepted at edge k. imem_we is high for exactly the cycle after edge k, i.e. until edge k+1. The memory captures the word at edge k+1.
- Throughput: a word takes at least 5 cycles (4 byte cycles plus 1 WRITE cycle).
- Gaps in byte_valid stall the current state with no loss of partial data.
- Last word: DONE is entered at the edge ending WRITE. cpu_hold falls at that same edge, so the processor can fetch from address 0 on the following cycle.
- Reset mid-load discards the partial word and any pending write and forces the reset values. An imem_we already on the memory bus at that edge is dropped.
- start asserted together with a byte transfer in DONE/ERR: the byte is not accepted. LEN_LO begins next cycle.

## Test plan
- Reset: assert rst_n=0 mid-cycle with no clock edge → every output takes its reset value immediately; cpu_hold=1, byte_ready=0.
- Basic load: start, then bytes 02 00 13 05 50 00 93 05 a0 00 with valid held high → exactly two writes: (addr 0x0, data 0x00500513) and (addr 0x4, data 0x00a00593), one cycle each; then done=1, cpu_hold=0, busy=0.
- Stalls: same stream with random valid gaps of 0–5 cycles → identical two writes; imem_we never high for 2 consecutive cycles; no write before the 4th byte of each word.
- Header rejection: header 00 00 → error=1, no imem_we. Header 01 01 (N=257, DEPTH_WORDS=256) → error=1, no imem_we. start then a valid 1-word stream → error clears and the word is written at addr 0.
- Reset mid-load: load N=2; after the first write plus 2 data bytes, pulse rst_n low → reset values, only one write observed. A new start plus full stream → both writes occur correctly.
- Start handling: start pulses during DATA are ignored (write sequence unchanged). start in DONE → done=0, cpu_hold=1 on the next cycle, and a new load proceeds from addr 0.
